reg_file_multi: RTL and testbench
=================================

# reg_file_multi

Parametrised multi-read-port register file with write bypass, optional hard-wired zero register and a per-register pending-write scoreboard. It succeeds `regFile_param` as the datapath register file of the MIPS core. Decode reads operands through it. Issue claims destination registers through it. Writeback retires them. The scoreboard raises `busy` so the pipeline stalls on operands that are not yet ready.

## Interface
Parameters:
- `width`, 32, data bits per register
- `length`, 32, number of registers (power of two, ≥2); `AW = $clog2(length)`
- `nrd`, 2, number of read ports (1–4)
- `zero_reg`, 1, when 1 register 0 reads 0 and is never written or claimed
- `bypass`, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `we`  in  1  write enable
- `WS`  in  AW  write select
- `D`  in  width  write data
- `RS`  in  nrd*AW  read selects; port i is `RS[i*AW +: AW]`
- `Q`  out  nrd*width  read data; port i is `Q[i*width +: width]`
- `claim`  in  1  mark register `CS` pending
- `CS`  in  AW  claim select
- `busy`  out  nrd  bit i high when port i's source is pending and not bypassed
- `pend`  out  length  raw scoreboard vector

## Operation
- Storage is `length` × `width` flops.
- Write: at the rising edge with `reset`=1 and `we`=1, `reg[WS] <= D`. If `zero_reg`=1 and `WS`=0, the write is dropped.
- Read, combinational, for each port i:
  - `zero_reg` and `RS[i]`=0 → `Q[i]`=0.
  - Otherwise, `bypass` and `we` and `WS==RS[i]` → `Q[i]=D`.
  - Otherwise `Q[i]=reg[RS[i]]`.
- Scoreboard: one bit `pend[k]` per register. Next-state per k:
  - `claim && CS==k` → 1. Claim has priority: a new producer supersedes the retiring one.
  - Otherwise `we && WS==k` → 0.
  - Otherwise hold.
  - Forced 0 for k=0 when `zero_reg`=1.
- Busy: `busy[i] = pend[RS[i]] & ~hit[i]`. `hit[i]` is the bypass condition above, i.e. the retiring write supplies the value this cycle. With `bypass`=0, `hit` is 0.
- A write to a register that is not pending is legal. It updates data and leaves `pend` at 0.
- No FSM. The scoreboard is the only control state. Duplicate claims are idempotent.

## Timing
- Reset (`reset`=0 at an edge) sets all registers to 0 and `pend` to 0. From the next cycle `Q`=0 on all ports and `busy`=0.
- Reset has priority over `we` and `claim` in the same cycle.
- Reset asserted mid-sequence discards all pending claims and data.
- Write latency: 1 edge to storage. With `bypass`=1, `Q` shows the value combinationally in the write cycle. With `bypass`=0, `Q` shows it one cycle later.
- Claim latency: `pend` and `busy` rise the cycle after the edge that samples `claim`.
- Claim and write to the same k in one cycle: data is written, `pend[k]` ends at 1.
- Claim of k and write of j≠k in one cycle: both take effect independently.
- `Q` and `busy` are pure functions of current state and inputs. There is no read-port latency.

## Structure
- Shared package `reg_file_pkg`:
  - `addr_w(length)` function
  - `MAX_RD = 4` constant
  - `ZERO_IDX = 0` constant
- Sub-module `reg_file_scoreboard`: holds the `pend` vector and its claim/retire logic, and computes `busy` from `RS` and `hit`. The parent holds storage, read muxes and bypass, and passes the `hit` vector down.
- Read muxes may reuse `mux_param`. The write decoder may reuse `demux_param`.

## Test plan
1. Assert `reset`=0 for 2 cycles with `we`=1, `WS`=5, `D`=0xDEAD. After release, all `Q`=0, `pend`=0, and register 5 reads 0.
2. Write `WS`=3, `D`=0x1234. Port 0 reads `RS`=3 in the same cycle → `Q[0]`=0x1234. Repeat with `bypass`=0 → same-cycle `Q[0]`=0, next cycle `Q[0]`=0x1234.
3. With `zero_reg`=1:
   - Write `WS`=0, `D`=0xFFFF_FFFF, then read `RS`=0 → `Q`=0.
   - Claim `CS`=0 → `pend[0]` stays 0.
4. Claim `CS`=7. Next cycle port 1 reads `RS`=7 → `busy[1]`=1. Then write `WS`=7, `D`=0x55 → `busy[1]`=0 in that cycle, `Q[1]`=0x55, and `pend[7]`=0 next cycle.
5. In one cycle: claim `CS`=9, write `WS`=9, `D`=0xA. Next cycle `reg[9]`=0xA and `pend[9]`=1.
6. Claim registers 2 and 4 in successive cycles, then pulse `reset`=0 once → `pend`=0, and `Q` on `RS`=2 reads 0.

Source files
------------

// File: rtl/reg_file_multi_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
// Latency: none (package only).
// Backpressure: none (package only).
package reg_file_pkg;

    // Upper bound on read ports supported by the read-mux / busy logic.
    localparam int MAX_RD   = 4;

    // Index of the optional hard-wired zero register.
    localparam int ZERO_IDX = 0;

    // Address width for a register file of the given depth; never below 1 bit.
    function automatic int addr_w(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

endpackage

// File: rtl/reg_file_multi_if.sv
// Bundles the write, claim and read-port signals of the register file.
// Latency: none (wiring only).
// Backpressure: none; the consumer stalls on busy rather than a ready signal.
interface reg_file_multi_if
    import reg_file_pkg::*;
#(
    parameter int width  = 32,
    parameter int length = 32,
    parameter int nrd    = 2
);
    localparam int AW = addr_w(length);

    logic                   we;
    logic [AW-1:0]          WS;
    logic [width-1:0]       D;
    logic [nrd*AW-1:0]      RS;
    logic [nrd*width-1:0]   Q;
    logic                   claim;
    logic [AW-1:0]          CS;
    logic [nrd-1:0]         busy;
    logic [length-1:0]      pend;

    // Pipeline side: drives writes, claims and read selects, observes data and stall status.
    modport master (
        output we, WS, D, RS, claim, CS,
        input  Q, busy, pend
    );

    // Register file side.
    modport slave (
        input  we, WS, D, RS, claim, CS,
        output Q, busy, pend
    );

endinterface

// File: rtl/reg_file_multi_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by claim, cleared by the retiring write.
// Latency: pend updates one edge after claim/write; busy is combinational from pend, RS and hit.
// Backpressure: none; busy is the stall indication for the pipeline.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int length   = 32,
    parameter int nrd      = 2,
    parameter int zero_reg = 1,
    parameter int AW       = addr_w(length)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                claim,
    input  logic [AW-1:0]       CS,
    input  logic                we,
    input  logic [AW-1:0]       WS,
    input  logic [nrd*AW-1:0]   RS,
    input  logic [nrd-1:0]      hit,
    output logic [nrd-1:0]      busy,
    output logic [length-1:0]   pend
);

    logic [length-1:0] pend_q;
    logic [length-1:0] pend_nxt;

    // Next-state per register: a new claim beats a retiring write so a fresh producer is never lost.
    always_comb begin
        pend_nxt = pend_q;
        for (int k = 0; k < length; k++) begin
            if (claim && (CS == AW'(k))) begin
                pend_nxt[k] = 1'b1;
            end else if (we && (WS == AW'(k))) begin
                pend_nxt[k] = 1'b0;
            end
        end
        if (zero_reg != 0) begin
            pend_nxt[ZERO_IDX] = 1'b0;
        end
    end

    // Scoreboard state; reset discards every outstanding claim.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    // A port stalls when its source is pending, unless the retiring write is forwarded to it right now.
    always_comb begin
        busy = '0;
        for (int i = 0; i < nrd; i++) begin
            busy[i] = pend_q[RS[i*AW +: AW]] & ~hit[i];
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/reg_file_multi.sv
// Multi-read-port register file with write bypass, optional zero register and pending-write scoreboard.
// Latency: reads combinational; writes land one edge later (bypassed same cycle when enabled).
// Backpressure: none; busy per read port tells the pipeline to stall on unready operands.
module reg_file_multi
    import reg_file_pkg::*;
#(
    parameter int width    = 32,
    parameter int length   = 32,
    parameter int nrd      = 2,
    parameter int zero_reg = 1,
    parameter int bypass   = 1
) (
    input  logic              clk,
    input  logic              reset,
    reg_file_multi_if.slave   bus
);

    localparam int AW = addr_w(length);

    if (nrd < 1 || nrd > MAX_RD) begin : g_chk_nrd
        $error("reg_file_multi: nrd must be between 1 and MAX_RD");
    end

    logic [width-1:0]     mem [length];
    logic [length-1:0]    wr_sel;
    logic [nrd-1:0]       hit;
    logic [nrd*width-1:0] q_vec;
    logic [AW-1:0]        rs_i;
    logic                 is_zero;

    // Write decoder; the zero register never accepts a write.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < length; k++) begin
            wr_sel[k] = bus.we && (bus.WS == AW'(k));
        end
        if (zero_reg != 0) begin
            wr_sel[ZERO_IDX] = 1'b0;
        end
    end

    // Register storage; reset clears all data and takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < length; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < length; k++) begin
                if (wr_sel[k]) begin
                    mem[k] <= bus.D;
                end
            end
        end
    end

    // Read muxes: zero register first, then same-cycle forwarding of the write, then storage.
    always_comb begin
        q_vec   = '0;
        hit     = '0;
        rs_i    = '0;
        is_zero = 1'b0;
        for (int i = 0; i < nrd; i++) begin
            rs_i    = bus.RS[i*AW +: AW];
            is_zero = (zero_reg != 0) && (rs_i == AW'(ZERO_IDX));
            hit[i]  = (bypass != 0) && bus.we && (bus.WS == rs_i) && !is_zero;
            if (is_zero) begin
                q_vec[i*width +: width] = '0;
            end else if (hit[i]) begin
                q_vec[i*width +: width] = bus.D;
            end else begin
                q_vec[i*width +: width] = mem[rs_i];
            end
        end
    end

    assign bus.Q = q_vec;

    reg_file_scoreboard #(
        .length   (length),
        .nrd      (nrd),
        .zero_reg (zero_reg),
        .AW       (AW)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .claim (bus.claim),
        .CS    (bus.CS),
        .we    (bus.we),
        .WS    (bus.WS),
        .RS    (bus.RS),
        .hit   (hit),
        .busy  (bus.busy),
        .pend  (bus.pend)
    );

endmodule

// File: tb/tb_reg_file_multi.sv
// Directed bench for reg_file_multi: stimulus queues expected values, a negedge monitor compares.
// Two instances share stimulus: defaults (zero_reg=1, bypass=1) and a plain one (zero_reg=0, bypass=0).
// Outputs are combinational, so every queued expectation is checked at the next falling edge.
module tb_reg_file_multi;

    localparam int K_QA    = 0;  // Q of default instance, port idx
    localparam int K_BUSYA = 1;  // busy bit of default instance, port idx
    localparam int K_PENDA = 2;  // pend bit idx of default instance
    localparam int K_PENDV = 3;  // full pend vector of default instance
    localparam int K_QB    = 4;  // Q of plain instance, port idx
    localparam int K_BUSYB = 5;  // busy bit of plain instance, port idx
    localparam int K_PENDB = 6;  // pend bit idx of plain instance

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    string       e_name [$];
    int          e_kind [$];
    int          e_idx  [$];
    logic [31:0] e_val  [$];

    reg_file_multi_if #(.width(32), .length(32), .nrd(2)) bus_a ();
    reg_file_multi_if #(.width(32), .length(32), .nrd(2)) bus_b ();

    reg_file_multi u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    reg_file_multi #(
        .width    (32),
        .length   (32),
        .nrd      (2),
        .zero_reg (0),
        .bypass   (0)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus to both instances just after the rising edge.
    task automatic drive(input logic rst, input logic w, input logic [4:0] ws,
                         input logic [31:0] d, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic c, input logic [4:0] cs);
        @(posedge clk);
        #1;
        reset       = rst;
        bus_a.we    = w;    bus_b.we    = w;
        bus_a.WS    = ws;   bus_b.WS    = ws;
        bus_a.D     = d;    bus_b.D     = d;
        bus_a.RS    = {rs1, rs0};
        bus_b.RS    = {rs1, rs0};
        bus_a.claim = c;    bus_b.claim = c;
        bus_a.CS    = cs;   bus_b.CS    = cs;
    endtask

    task automatic expect_val(input string name, input int kind, input int idx,
                              input logic [31:0] val);
        e_name.push_back(name);
        e_kind.push_back(kind);
        e_idx.push_back(idx);
        e_val.push_back(val);
    endtask

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_QA:    return bus_a.Q[idx*32 +: 32];
            K_BUSYA: return {31'b0, bus_a.busy[idx]};
            K_PENDA: return {31'b0, bus_a.pend[idx]};
            K_PENDV: return bus_a.pend;
            K_QB:    return bus_b.Q[idx*32 +: 32];
            K_BUSYB: return {31'b0, bus_b.busy[idx]};
            K_PENDB: return {31'b0, bus_b.pend[idx]};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: drain every expectation queued for the current cycle against live DUT outputs.
    always @(negedge clk) begin : monitor
        string       n;
        int          k;
        int          ix;
        logic [31:0] v;
        logic [31:0] act;
        while (e_kind.size() > 0) begin
            n   = e_name.pop_front();
            k   = e_kind.pop_front();
            ix  = e_idx.pop_front();
            v   = e_val.pop_front();
            act = actual(k, ix);
            checks++;
            if (act !== v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", n, act, v);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b0;
        bus_a.we = 1'b0; bus_a.WS = '0; bus_a.D = '0; bus_a.RS = '0; bus_a.claim = 1'b0; bus_a.CS = '0;
        bus_b.we = 1'b0; bus_b.WS = '0; bus_b.D = '0; bus_b.RS = '0; bus_b.claim = 1'b0; bus_b.CS = '0;

        // Reset for two cycles while a write to r5 is offered: reset must win.
        drive(0, 1, 5, 32'hDEAD, 5, 0, 0, 0);
        drive(0, 1, 5, 32'hDEAD, 5, 0, 0, 0);

        drive(1, 0, 0, 0, 5, 3, 0, 0);
        expect_val("rst_q0_r5",   K_QA,    0, 32'h0);
        expect_val("rst_q1",      K_QA,    1, 32'h0);
        expect_val("rst_pend",    K_PENDV, 0, 32'h0);
        expect_val("rst_busy0",   K_BUSYA, 0, 32'h0);
        expect_val("rst_busy1",   K_BUSYA, 1, 32'h0);
        expect_val("rst_b_q0_r5", K_QB,    0, 32'h0);

        // Write r3 and read it in the same cycle: forwarded on A, stale on B.
        drive(1, 1, 3, 32'h1234, 3, 3, 0, 0);
        expect_val("byp_q0",      K_QA,    0, 32'h1234);
        expect_val("nobyp_q0",    K_QB,    0, 32'h0);
        expect_val("byp_busy0",   K_BUSYA, 0, 32'h0);

        drive(1, 0, 0, 0, 3, 3, 0, 0);
        expect_val("wr_q0",       K_QA,    0, 32'h1234);
        expect_val("nobyp_q0_d1", K_QB,    0, 32'h1234);
        expect_val("nobyp_q1_d1", K_QB,    1, 32'h1234);

        // Write and claim r0: ignored on A (zero register), honoured on B.
        drive(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        expect_val("zero_byp_q0", K_QA,    0, 32'h0);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_val("zero_q0",     K_QA,    0, 32'h0);
        expect_val("zero_pend0",  K_PENDA, 0, 32'h0);
        expect_val("zero_busy0",  K_BUSYA, 0, 32'h0);
        expect_val("b_r0_q0",     K_QB,    0, 32'hFFFF_FFFF);
        expect_val("b_r0_pend0",  K_PENDB, 0, 32'h1);

        // Claim r7, then retire it with a write.
        drive(1, 0, 0, 0, 0, 7, 1, 7);
        expect_val("clm7_busy1_d0", K_BUSYA, 1, 32'h0);
        expect_val("clm7_pend_d0",  K_PENDA, 7, 32'h0);

        drive(1, 0, 0, 0, 0, 7, 0, 0);
        expect_val("clm7_busy1",  K_BUSYA, 1, 32'h1);
        expect_val("clm7_pend",   K_PENDA, 7, 32'h1);

        drive(1, 1, 7, 32'h55, 0, 7, 0, 0);
        expect_val("ret7_busy1",  K_BUSYA, 1, 32'h0);
        expect_val("ret7_q1",     K_QA,    1, 32'h55);
        expect_val("ret7_pend",   K_PENDA, 7, 32'h1);
        expect_val("ret7_b_busy1", K_BUSYB, 1, 32'h1);
        expect_val("ret7_b_q1",   K_QB,    1, 32'h0);

        drive(1, 0, 0, 0, 0, 7, 0, 0);
        expect_val("ret7_pend_d1", K_PENDA, 7, 32'h0);
        expect_val("ret7_busy1_d1", K_BUSYA, 1, 32'h0);
        expect_val("ret7_q1_d1",  K_QA,    1, 32'h55);

        // Claim and write r9 in one cycle: data lands, claim survives.
        drive(1, 1, 9, 32'hA, 9, 7, 1, 9);
        expect_val("cw9_q0",      K_QA,    0, 32'hA);
        expect_val("cw9_busy0",   K_BUSYA, 0, 32'h0);

        drive(1, 0, 0, 0, 9, 7, 0, 0);
        expect_val("cw9_q0_d1",   K_QA,    0, 32'hA);
        expect_val("cw9_pend",    K_PENDA, 9, 32'h1);
        expect_val("cw9_busy0_d1", K_BUSYA, 0, 32'h1);

        // Claim r2 while writing r4, then claim r4.
        drive(1, 1, 4, 32'h44, 2, 4, 1, 2);
        expect_val("c2w4_q1",     K_QA,    1, 32'h44);
        expect_val("c2w4_busy0",  K_BUSYA, 0, 32'h0);

        drive(1, 0, 0, 0, 2, 4, 1, 4);
        expect_val("c4_pend2",    K_PENDA, 2, 32'h1);
        expect_val("c4_q1",       K_QA,    1, 32'h44);
        expect_val("c4_busy0",    K_BUSYA, 0, 32'h1);
        expect_val("c4_busy1_d0", K_BUSYA, 1, 32'h0);

        drive(1, 0, 0, 0, 2, 4, 0, 0);
        expect_val("pre_rst_pend", K_PENDV, 0, 32'h0000_0214);
        expect_val("pre_rst_busy0", K_BUSYA, 0, 32'h1);
        expect_val("pre_rst_busy1", K_BUSYA, 1, 32'h1);

        // Single reset pulse with a write and claim offered: all must be discarded.
        drive(0, 1, 2, 32'h77, 2, 4, 1, 6);

        drive(1, 0, 0, 0, 2, 0, 0, 0);
        expect_val("post_rst_pend", K_PENDV, 0, 32'h0);
        expect_val("post_rst_q0_r2", K_QA,   0, 32'h0);
        expect_val("post_rst_busy0", K_BUSYA, 0, 32'h0);
        expect_val("post_rst_b_q1_r0", K_QB, 1, 32'h0);
        expect_val("post_rst_b_pend0", K_PENDB, 0, 32'h0);

        drive(1, 0, 0, 0, 2, 4, 0, 0);
        expect_val("post_rst_q1_r4", K_QA,   1, 32'h0);
        expect_val("post_rst_busy1", K_BUSYA, 1, 32'h0);
        expect_val("post_rst_pend6", K_PENDA, 6, 32'h0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (e_kind.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", e_kind.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
